x_mem_sp_clr: RTL

// - Parametrised single-port synchronous RAM: generalised DW x DEPTH storage with a hardware clear engine.
// - Clear engine zeroes every word after reset and on request.
// - Reads return a registered result with a valid strobe.
// - Drop-in store for DAC sample/pattern buffers; defaults match the 2048x2 pattern store.

---
 rtl/x_mem_sp_clr.sv | 92 +++++++++
 1 files changed

// File: rtl/x_mem_sp_clr.sv
// Single-port synchronous RAM (DW x DEPTH) with a hardware clear engine that zeroes
// every word after reset and on i_clr. Build with X_MEM_SP_CLR_BYPASS_EN for write-through on we&re.
module x_mem_sp_clr #(
  parameter  int DW    = 2,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_clr,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_rvalid,
  output logic          o_busy,
  output logic          o_dbg_state
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];
  logic          in_range;
  logic          acc_we;
  logic          acc_re;
  logic          last;

  // Addresses past DEPTH exist only when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << AW)) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = ({1'b0, i_addr} < (AW + 1)'(DEPTH));
    end
  endgenerate

  assign o_busy      = (state == ST_CLEAR);
  assign o_dbg_state = state;
  assign acc_we      = !o_busy && i_we;
  assign acc_re      = !o_busy && i_re;
  assign last        = (cnt == AW'(DEPTH - 1));

  // i_clr has priority so a request during a clear restarts the sweep from word 0.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (i_clr) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      if (last) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The clear engine shares the single write port with user writes.
  always_ff @(posedge i_clk) begin
    if (o_busy) begin
      mem[cnt] <= '0;
    end else if (acc_we && in_range) begin
      mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= 1'b0;
      if (acc_we && acc_re) begin
`ifdef X_MEM_SP_CLR_BYPASS_EN
        o_rvalid <= 1'b1;
        o_rdata  <= in_range ? i_wdata : '0;
`endif
      end else if (acc_re) begin
        o_rvalid <= 1'b1;
        o_rdata  <= in_range ? mem[i_addr] : '0;
      end
    end
  end

endmodule
